// File: rtl/fetch_ram_wr_ctrl.sv
// Write-side controller for the fetch buffer RAM: turns 4-pixel beats into half-word writes,
// lower half first, and pulses done_o once all 2*N beats of a load have been written.
module fetch_ram_wr_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [7:0]               word_num_i,
  input  logic                     abort_i,
  input  logic                     in_valid_i,
  input  logic [PIXEL_WIDTH*4-1:0] in_data_i,
  output logic                     in_ready_o,
  output logic [1:0]               wr_we_o,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [PIXEL_WIDTH*8-1:0] wr_data_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         last_idx;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [7:0]               num_q, num_d;
  logic [1:0]               we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [PIXEL_WIDTH*8-1:0] data_q, data_d;
  logic                     accept;

  assign in_ready_o = (state_q == StLoad) && !abort_i;
  assign accept     = in_valid_i && in_ready_o;
  // Index of the final beat, 2*N-1; only meaningful while in StLoad where N != 0.
  assign last_idx   = CNT_W'({num_q, 1'b0}) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    num_d   = num_q;
    we_d    = 2'b00;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d  = base_addr_i;
          num_d   = word_num_i;
          cnt_d   = '0;
          state_d = (word_num_i == 8'd0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (accept) begin
          // Even beats fill the lower half, odd beats the upper half of the same word.
          we_d   = cnt_q[0] ? 2'b10 : 2'b01;
          addr_d = base_q + ADDR_W'(cnt_q >> 1);
          data_d = {2{in_data_i}};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == last_idx) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
      num_q   <= '0;
      we_q    <= 2'b00;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      num_q   <= num_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign wr_we_o   = we_q;
  assign wr_addr_o = addr_q;
  assign wr_data_o = data_q;

endmodule

// File: tb/tb_fetch_ram_wr_ctrl.sv
// Bench for fetch_ram_wr_ctrl: directed scenarios plus random traffic, all checked every cycle
// against a transaction-level model of the load protocol.
module tb_fetch_ram_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  base_addr_i = '0;
  logic [7:0]  word_num_i = '0;
  logic        abort_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o;
  logic [1:0]  wr_we_o;
  logic [7:0]  wr_addr_o;
  logic [63:0] wr_data_o;
  logic        busy_o;
  logic        done_o;

  fetch_ram_wr_ctrl #(.ADDR_W(8), .CNT_W(9), .PIXEL_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .word_num_i (word_num_i),
    .abort_i    (abort_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .wr_we_o    (wr_we_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Model: phase 0 = no load, 1 = collecting beats, 2 = completion cycle.
  int          m_phase = 0;
  int          m_k = 0;
  int          m_n = 0;
  int          m_base = 0;
  logic [1:0]  e_we = 2'b00;
  logic [7:0]  e_addr = '0;
  logic [63:0] e_data = '0;

  typedef struct {
    logic [1:0] we;
    logic [7:0] addr;
    int         t;
    bit         done;
  } wr_t;
  wr_t log_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_k = 0; m_n = 0; m_base = 0;
      e_we = 2'b00; e_addr = '0; e_data = '0;
    end else begin
      cyc++;
      e_we = 2'b00;
      case (m_phase)
        0: if (start_i) begin
          m_base  = int'(base_addr_i);
          m_n     = int'(word_num_i);
          m_k     = 0;
          m_phase = (m_n == 0) ? 2 : 1;
        end
        1: if (abort_i) begin
          m_phase = 0;
        end else if (in_valid_i) begin
          e_we   = (m_k % 2 == 0) ? 2'b01 : 2'b10;
          e_addr = 8'((m_base + m_k / 2) % 256);
          e_data = {in_data_i, in_data_i};
          m_k++;
          if (m_k == 2 * m_n) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Outputs are compared on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("wr_we", 64'(wr_we_o), 64'(e_we));
    chk("wr_addr", 64'(wr_addr_o), 64'(e_addr));
    chk("wr_data", wr_data_o, e_data);
    chk("busy", 64'(busy_o), 64'(m_phase != 0));
    chk("done", 64'(done_o), 64'(m_phase == 2));
    chk("in_ready", 64'(in_ready_o), 64'(m_phase == 1 && !abort_i));
    if (wr_we_o != 2'b00) log_q.push_back('{we: wr_we_o, addr: wr_addr_o, t: cyc, done: done_o});
    if (done_o) done_cnt++;
  end

  task automatic step(input bit st, input bit v, input bit ab, input logic [7:0] b,
                      input logic [7:0] n);
    @(posedge clk);
    #1;
    start_i = st; in_valid_i = v; abort_i = ab; base_addr_i = b; word_num_i = n;
    in_data_i = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      if (!busy_o) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL idle_timeout: busy=%b, expected 0 within 60 cycles", busy_o);
  endtask

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  int t0;
  logic [7:0] wrap_addr [8];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_we", 64'(wr_we_o), 64'h0);
    chk("reset_addr", 64'(wr_addr_o), 64'h0);
    chk("reset_busy", 64'(busy_o), 64'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Basic load: base 0x10, two words, consecutive beats.
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h10, 8'd2);
    t0 = cyc;
    repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_idle();
    chk("basic_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk("basic_we0", 64'(log_q[0].we), 64'h1);
      chk("basic_we1", 64'(log_q[1].we), 64'h2);
      chk("basic_we2", 64'(log_q[2].we), 64'h1);
      chk("basic_we3", 64'(log_q[3].we), 64'h2);
      chk("basic_addr0", 64'(log_q[0].addr), 64'h10);
      chk("basic_addr1", 64'(log_q[1].addr), 64'h10);
      chk("basic_addr2", 64'(log_q[2].addr), 64'h11);
      chk("basic_addr3", 64'(log_q[3].addr), 64'h11);
      chk("basic_first_t", 64'(log_q[0].t - t0), 64'd2);
      chk("basic_last_t", 64'(log_q[3].t - t0), 64'd5);
      chk("basic_done_with_last", 64'(log_q[3].done), 64'd1);
    end
    chk("basic_done_cnt", 64'(done_cnt), 64'd1);

    // Backpressure: valid pattern 1,0,0,1.
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h40, 8'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_idle();
    chk("bp_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("bp_we0", 64'(log_q[0].we), 64'h1);
      chk("bp_we1", 64'(log_q[1].we), 64'h2);
      chk("bp_gap", 64'(log_q[1].t - log_q[0].t), 64'd3);
      chk("bp_done", 64'(log_q[1].done), 64'd1);
    end

    // Address wrap: base 0xFE, four words.
    wrap_addr = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01, 8'h01};
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'hFE, 8'd4);
    repeat (8) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_idle();
    chk("wrap_count", 64'(log_q.size()), 64'd8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("wrap_addr", 64'(log_q[i].addr), 64'(wrap_addr[i]));
    end

    // Zero-length load.
    clear_log();
    step(1'b1, 1'b1, 1'b0, 8'h33, 8'd0);
    wait_idle();
    chk("zero_writes", 64'(log_q.size()), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);

    // Abort after three beats, together with a valid fourth beat.
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h60, 8'd8);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    wait_idle();
    chk("abort_writes", 64'(log_q.size()), 64'd3);
    chk("abort_done_cnt", 64'(done_cnt), 64'd0);

    // start_i during a load must not change base or length.
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h20, 8'd2);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h80, 8'd5);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_idle();
    chk("ign_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk("ign_addr1", 64'(log_q[1].addr), 64'h20);
      chk("ign_addr3", 64'(log_q[3].addr), 64'h21);
    end

    // Reset mid-load after five beats, then a clean load.
    step(1'b1, 1'b0, 1'b0, 8'h30, 8'd8);
    repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_we", 64'(wr_we_o), 64'h0);
    chk("rst_addr", 64'(wr_addr_o), 64'h0);
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_ready", 64'(in_ready_o), 64'h0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h50, 8'd1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    wait_idle();
    chk("post_rst_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk("post_rst_we0", 64'(log_q[0].we), 64'h1);
      chk("post_rst_addr0", 64'(log_q[0].addr), 64'h50);
      chk("post_rst_we1", 64'(log_q[1].we), 64'h2);
    end

    // Random traffic: starts (often ignored), gaps, occasional aborts.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
           8'($urandom), 8'($urandom_range(0, 5)));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
